// File: rtl/mpu_pkg.sv
// Shared definitions for the matrix processing unit sequencer: operation
// encodings, FSM states and the index/width/range helpers used by the datapath.
package mpu_pkg;

  // Operation encodings carried on the 3-bit operation input; 6 and 7 are reserved.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SCL = 3'd2;
  localparam logic [2:0] OP_NEG = 3'd3;
  localparam logic [2:0] OP_TRN = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width that holds any sum of n products of two w-bit signed values.
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  // Width of a row/column counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of element (r,c) in a flattened row-major n x n matrix of w-bit elements.
  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

  // True when v cannot be represented as a w-bit two's-complement value.
  function automatic logic out_of_range(input longint v, input int w);
    longint max_v;
    longint min_v;
    max_v = (longint'(1) <<< (w - 1)) - 1;
    min_v = -max_v - 1;
    return (v > max_v) || (v < min_v);
  endfunction

endpackage

// File: rtl/mpu_dot_product.sv
// Combinational N-lane signed dot product. Lanes whose enable bit is low
// contribute nothing, so rows/columns beyond the active size are ignored.
module mpu_dot_product
  import mpu_pkg::*;
#(
  parameter int N     = 5,
  parameter int W     = 8,
  parameter int ACC_W = acc_width(N, W)
) (
  input  logic [N*W-1:0]          i_row_a,
  input  logic [N*W-1:0]          i_col_b,
  input  logic [N-1:0]            i_lane_en,
  output logic signed [ACC_W-1:0] o_sum
);

  // Accumulate the enabled lane products at full precision.
  always_comb begin
    o_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (i_lane_en[k]) begin
        // NOTE: blocking assignment is deliberate here: each lane adds to the
        // partial sum produced by the previous iteration in the same evaluation.
        o_sum = o_sum + ACC_W'(signed'(i_row_a[k*W +: W])) * ACC_W'(signed'(i_col_b[k*W +: W]));
      end
    end
  end

endmodule

// File: rtl/mpu_sequencer.sv
// Handshaked N x N signed matrix unit: element-wise ops one row per cycle,
// matrix multiply one element per cycle, with error and sticky overflow flags.
module mpu_sequencer
  import mpu_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [7:0]       size,
  input  logic [W-1:0]     factor,
  input  logic [N*N*W-1:0] matrix_a,
  input  logic [N*N*W-1:0] matrix_b,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             overflow,
  output logic [N*N*W-1:0] result
);

  localparam int ACC_W = acc_width(N, W);
  localparam int IDX_W = idx_width(N);

  state_e                  r_state;
  state_e                  w_state_next;

  logic [2:0]              r_op;
  logic [IDX_W-1:0]        r_last_idx;
  logic signed [W-1:0]     r_factor;
  logic [N*N*W-1:0]        r_a;
  logic [N*N*W-1:0]        r_b;

  logic [IDX_W-1:0]        r_row;
  logic [IDX_W-1:0]        r_col;
  logic [N*N*W-1:0]        r_result;
  logic                    r_error;
  logic                    r_overflow;

  logic                    w_accept;
  logic                    w_illegal;
  logic                    w_last;
  logic [N*W-1:0]          w_row_a;
  logic [N*W-1:0]          w_col_b;
  logic [N-1:0]            w_lane_en;
  logic [N*W-1:0]          w_row_res;
  logic [N-1:0]            w_lane_ovf;
  logic signed [ACC_W-1:0] w_dot;
  logic                    w_dot_ovf;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_illegal = (size == 8'd0) || (int'(size) > N) || (operation > OP_MUL);
  assign w_last    = (r_op == OP_MUL) ? ((r_row == r_last_idx) && (r_col == r_last_idx))
                                      : (r_row == r_last_idx);

  // Per-column lanes: operand extraction for the dot product and the
  // element-wise result of the active row.
  for (genvar c = 0; c < N; c++) begin : g_col
    logic signed [ACC_W-1:0] w_a;
    logic signed [ACC_W-1:0] w_b;
    logic signed [ACC_W-1:0] w_t;
    logic signed [ACC_W-1:0] w_f;
    logic signed [ACC_W-1:0] w_full;

    assign w_row_a[c*W +: W] = r_a[elem_lsb(int'(r_row), c, N, W) +: W];
    assign w_col_b[c*W +: W] = r_b[elem_lsb(c, int'(r_col), N, W) +: W];
    assign w_lane_en[c]      = (c <= int'(r_last_idx));

    assign w_a = ACC_W'(signed'(w_row_a[c*W +: W]));
    assign w_b = ACC_W'(signed'(r_b[elem_lsb(int'(r_row), c, N, W) +: W]));
    assign w_t = ACC_W'(signed'(r_a[elem_lsb(c, int'(r_row), N, W) +: W]));
    assign w_f = ACC_W'(r_factor);

    // Full-precision element-wise result for column c of the active row.
    always_comb begin
      case (r_op)
        OP_ADD:  w_full = w_a + w_b;
        OP_SUB:  w_full = w_a - w_b;
        OP_SCL:  w_full = w_a * w_f;
        OP_NEG:  w_full = -w_a;
        OP_TRN:  w_full = w_t;
        default: w_full = '0;
      endcase
    end

    assign w_row_res[c*W +: W] = w_full[W-1:0];
    assign w_lane_ovf[c]       = w_lane_en[c] && out_of_range(longint'(w_full), W);
  end

  mpu_dot_product #(
    .N     (N),
    .W     (W),
    .ACC_W (ACC_W)
  ) u_dot (
    .i_row_a   (w_row_a),
    .i_col_b   (w_col_b),
    .i_lane_en (w_lane_en),
    .o_sum     (w_dot)
  );

  assign w_dot_ovf = out_of_range(longint'(w_dot), W);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode and the busy/done handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned and infers a latch.
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_next = w_illegal ? ST_DONE : ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture on an accepted start; inputs are free to change afterwards.
  // NOTE: no reset on these: they are always loaded by the accepting edge
  // before anything in RUN reads them, so a reset would only add fan-out.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op       <= operation;
      r_last_idx <= IDX_W'(size - 8'd1);
      r_factor   <= factor;
      r_a        <= matrix_a;
      r_b        <= matrix_b;
    end
  end

  // Result, flags and row/column counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result   <= '0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
    end else if (w_accept) begin
      r_error    <= w_illegal;
      r_overflow <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      if (!w_illegal) r_result <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_op == OP_MUL) begin
        r_result[elem_lsb(int'(r_row), int'(r_col), N, W) +: W] <= w_dot[W-1:0];
        r_overflow <= r_overflow | w_dot_ovf;
        if (r_col == r_last_idx) begin
          r_col <= '0;
          r_row <= w_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          if (w_lane_en[c]) r_result[elem_lsb(int'(r_row), c, N, W) +: W] <= w_row_res[c*W +: W];
        end
        r_overflow <= r_overflow | (|w_lane_ovf);
        r_row      <= w_last ? '0 : r_row + 1'b1;
      end
    end
  end

  assign result   = r_result;
  assign error    = r_error;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_mpu_sequencer.sv
// Directed self-checking bench for mpu_sequencer (N=5, W=8).
module tb_mpu_sequencer;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int NW = N * N * W;

  localparam logic [2:0] T_ADD = 3'd0;
  localparam logic [2:0] T_SUB = 3'd1;
  localparam logic [2:0] T_SCL = 3'd2;
  localparam logic [2:0] T_NEG = 3'd3;
  localparam logic [2:0] T_TRN = 3'd4;
  localparam logic [2:0] T_MUL = 3'd5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    operation;
  logic [7:0]    size;
  logic [W-1:0]  factor;
  logic [NW-1:0] matrix_a;
  logic [NW-1:0] matrix_b;
  logic          busy;
  logic          done;
  logic          error;
  logic          overflow;
  logic [NW-1:0] result;

  int checks = 0;
  int errors = 0;

  mpu_sequencer #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .operation (operation),
    .size      (size),
    .factor    (factor),
    .matrix_a  (matrix_a),
    .matrix_b  (matrix_b),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .overflow  (overflow),
    .result    (result)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] set_el(input logic [NW-1:0] v, input int r, input int c, input int x);
    v[(r*N+c)*W +: W] = x[W-1:0];
    return v;
  endfunction

  function automatic logic [W-1:0] get_el(input logic [NW-1:0] v, input int r, input int c);
    return v[(r*N+c)*W +: W];
  endfunction

  function automatic logic [NW-1:0] fill(input int x);
    logic [NW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) v = set_el(v, r, c, x);
    return v;
  endfunction

  // Issue one command, scramble the inputs, wait for done, check latency,
  // busy length and that done drops after one cycle. Returns in IDLE.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [7:0] sz,
                        input logic [W-1:0] fac, input logic [NW-1:0] a, input logic [NW-1:0] b,
                        input int exp_lat, input int exp_busy, input bit stray);
    int lat;
    int nb;
    operation = op; size = sz; factor = fac; matrix_a = a; matrix_b = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    matrix_a = ~a; matrix_b = ~b; factor = ~fac; operation = 3'd7; size = 8'd0;
    lat = 1;
    nb  = 0;
    while (!done && lat < 200) begin
      if (busy) nb++;
      if (stray && lat == 2) begin
        start = 1'b1; operation = T_ADD; size = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, NW'(lat), NW'(exp_lat));
    check({tag, " busy cycles"}, NW'(nb), NW'(exp_busy));
    @(posedge clock); #1;
    check({tag, " done/busy after pulse"}, {done, busy}, '0);
  endtask

  initial begin
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic [NW-1:0] bb;
    logic [NW-1:0] e;
    logic [NW-1:0] prev;
    int sq [9];
    int seen;

    reset_n = 1'b0; start = 1'b0; operation = '0; size = '0; factor = '0;
    matrix_a = '0; matrix_b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset overflow", overflow, 0);
    check("reset result", result, '0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Add, size 2: 3+4 in the 2x2 corner, zero elsewhere.
    do_cmd("add", T_ADD, 8'd2, 8'd0, fill(3), fill(4), 3, 2, 1'b0);
    e = '0;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) e = set_el(e, r, c, 7);
    check("add result", result, e);
    check("add overflow", overflow, 0);
    check("add error", error, 0);

    // Add with wrap: 100+100 -> -56.
    do_cmd("add_ovf", T_ADD, 8'd1, 8'd0, fill(100), fill(100), 2, 1, 1'b0);
    check("add_ovf result", result, set_el('0, 0, 0, -56));
    check("add_ovf overflow", overflow, 1);

    // Opposite of -128 wraps back to -128.
    do_cmd("neg", T_NEG, 8'd1, 8'd0, fill(-128), '0, 2, 1, 1'b0);
    check("neg result", result, set_el('0, 0, 0, -128));
    check("neg overflow", overflow, 1);

    // Subtract, size 3, overflow must be cleared by the new command.
    b = '0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) b = set_el(b, r, c, r + c);
    do_cmd("sub", T_SUB, 8'd3, 8'd0, fill(10), b, 4, 3, 1'b0);
    e = '0;
    e = set_el(e, 0, 0, 10); e = set_el(e, 0, 1, 9); e = set_el(e, 0, 2, 8);
    e = set_el(e, 1, 0, 9);  e = set_el(e, 1, 1, 8); e = set_el(e, 1, 2, 7);
    e = set_el(e, 2, 0, 8);  e = set_el(e, 2, 1, 7); e = set_el(e, 2, 2, 6);
    check("sub result", result, e);
    check("sub overflow", overflow, 0);

    // Multiply, size 3: identity times B gives B.
    bb = '0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) bb = set_el(bb, r, c, r * 3 + c + 1);
    a = '0;
    for (int i = 0; i < 3; i++) a = set_el(a, i, i, 1);
    do_cmd("mul_id", T_MUL, 8'd3, 8'd0, a, bb, 10, 9, 1'b0);
    check("mul_id result", result, bb);
    check("mul_id overflow", overflow, 0);

    // Multiply B*B: [30 36 42; 66 81 96; 102 126 150->-106].
    do_cmd("mul_sq", T_MUL, 8'd3, 8'd0, bb, bb, 10, 9, 1'b0);
    sq = '{30, 36, 42, 66, 81, 96, 102, 126, -106};
    e = '0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) e = set_el(e, r, c, sq[r*3+c]);
    check("mul_sq result", result, e);
    check("mul_sq (0,0)", get_el(result, 0, 0), 8'd30);
    check("mul_sq (2,2)", get_el(result, 2, 2), 8'h96);
    check("mul_sq overflow", overflow, 1);

    // Transpose, full size 5.
    a = '0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) a = set_el(a, r, c, r * 5 + c);
    do_cmd("trn", T_TRN, 8'd5, 8'd0, a, '0, 6, 5, 1'b0);
    e = '0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) e = set_el(e, r, c, c * 5 + r);
    check("trn result", result, e);
    check("trn overflow", overflow, 0);

    // Scalar multiply by -2 on the same A.
    do_cmd("scl", T_SCL, 8'd5, 8'hFE, a, '0, 6, 5, 1'b0);
    e = '0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) e = set_el(e, r, c, -2 * (r * 5 + c));
    check("scl result", result, e);
    check("scl (1,1)", get_el(result, 1, 1), 8'hF4);
    check("scl overflow", overflow, 0);
    prev = e;

    // Illegal commands: error with done one cycle after start, result kept.
    do_cmd("ill_size0", T_ADD, 8'd0, 8'd0, fill(1), fill(1), 1, 0, 1'b0);
    check("ill_size0 error", error, 1);
    check("ill_size0 result", result, prev);
    do_cmd("ill_size6", T_ADD, 8'd6, 8'd0, fill(1), fill(1), 1, 0, 1'b0);
    check("ill_size6 error", error, 1);
    check("ill_size6 result", result, prev);
    do_cmd("ill_op6", 3'd6, 8'd2, 8'd0, fill(1), fill(1), 1, 0, 1'b0);
    check("ill_op6 error", error, 1);
    check("ill_op6 result", result, prev);

    // Stray start during a size-2 multiply is ignored: [1 2;3 4]*[5 6;7 8].
    a = '0; b = '0;
    a = set_el(a, 0, 0, 1); a = set_el(a, 0, 1, 2); a = set_el(a, 1, 0, 3); a = set_el(a, 1, 1, 4);
    b = set_el(b, 0, 0, 5); b = set_el(b, 0, 1, 6); b = set_el(b, 1, 0, 7); b = set_el(b, 1, 1, 8);
    do_cmd("mul_stray", T_MUL, 8'd2, 8'd0, a, b, 5, 4, 1'b1);
    e = '0;
    e = set_el(e, 0, 0, 19); e = set_el(e, 0, 1, 22); e = set_el(e, 1, 0, 43); e = set_el(e, 1, 1, 50);
    check("mul_stray result", result, e);
    check("mul_stray error", error, 0);
    @(posedge clock); #1;
    check("mul_stray no queued run", busy, 0);

    // Reset in the 4th busy cycle of a multiply.
    operation = T_MUL; size = 8'd3; factor = '0; matrix_a = bb; matrix_b = bb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst busy in 4th cycle", busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst overflow", overflow, 0);
    check("rst result", result, '0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done || busy) seen++;
    end
    check("rst no done after abort", NW'(seen), '0);

    // A fresh add completes normally after the abort.
    do_cmd("add_after_rst", T_ADD, 8'd1, 8'd0, set_el('0, 0, 0, 1), set_el('0, 0, 0, 2), 2, 1, 1'b0);
    check("add_after_rst result", result, set_el('0, 0, 0, 3));
    check("add_after_rst error", error, 0);
    check("add_after_rst overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpu_sequencer.md
Name: mpu_sequencer

Overview:
- Parametrised, handshaked successor to the single-cycle matrix operation unit; N×N signed matrices, configurable element width.
- Adds matrix multiply, a start/busy/done handshake, an active-size mask, and error and overflow reporting.
- Sits between the MPU command decoder and the result register file.
- Processes one row per cycle for element-wise ops and one element per cycle for multiply.

Parameters:
- N, 5, maximum matrix dimension.
- W, 8, signed element width in bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- operation  in  3  0 add, 1 sub, 2 scalar mul, 3 opposite, 4 transpose, 5 multiply, 6-7 reserved.
- size  in  8  active dimension; legal range 1..N.
- factor  in  W  signed scalar for op 2.
- matrix_a  in  N*N*W  signed; element (r,c) at bits [(r*N+c)*W +: W].
- matrix_b  in  N*N*W  same layout as matrix_a.
- busy  out  1  high while computing.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; illegal size or operation.
- overflow  out  1  sticky per command; any element truncated.
- result  out  N*N*W  signed result, same layout.

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, all counters 0, busy=done=error=overflow=0, result=0. Reset mid-operation aborts immediately; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE with start=1:
  - Latch operation, size, factor, matrix_a, matrix_b into internal operand registers; inputs may change afterwards.
  - Illegal command (size=0, size>N, or operation 6/7): go to DONE with error=1. result unchanged, busy never asserted.
  - Legal command: clear result to 0, clear overflow, row=col=0, go to RUN.
- RUN:
  - busy=1.
  - Ops 0-4: one active row r per cycle; each result element written for c<size.
    - add: a+b. sub: a−b. scalar mul: a*factor. opposite: −a. transpose: result(r,c)=a(c,r).
    - Ends after row size−1.
  - Op 5: one element per cycle in row-major order (r, then c).
    - result(r,c) = sum over k<size of a(r,k)*b(k,c), computed in an accumulator of 2W+clog2(N) bits.
    - Ends after element (size−1,size−1).
  - Busy duration: size cycles for ops 0-4; size*size cycles for op 5.
- Width rule: each full-precision result is truncated to its low W bits (two's-complement wrap). overflow is set if the full value lies outside [−2^(W−1), 2^(W−1)−1] (e.g. −(−128) for W=8).
- Elements with r≥size or c≥size stay 0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. done asserts size+1 cycles after start for ops 0-4, size²+1 for op 5, and 1 cycle after start for an error.
- result, error and overflow hold until the next accepted start.
- start while in RUN or DONE is ignored; there is no queueing.
- start coincident with reset release is ignored; the first start is accepted on the first edge with reset_n high.

Decomposition:
- Package mpu_pkg holds:
  - operation encoding constants (OP_ADD .. OP_MUL);
  - the accumulator width function;
  - element index/slice helper functions;
  - the saturation-range check function (overflow detection).
- Sub-module mpu_dot_product: combinational N-lane signed dot product with a lane-enable mask derived from size; instantiated once for op 5.

Test Plan:
- Add, size=2, A all 3, B all 4 -> result(0..1,0..1)=7, all other elements 0; busy high 2 cycles; done 3 cycles after start; overflow=0, error=0.
- Add overflow, size=1, a(0,0)=100, b(0,0)=100 -> result(0,0)=−56, overflow=1. Then opposite with a(0,0)=−128 -> result −128, overflow=1.
- Multiply, size=3, A=identity, B=[1 2 3;4 5 6;7 8 9] -> result=B; busy 9 cycles. Then A=B=[1 2 3;4 5 6;7 8 9] -> row 0 = 30 36 42, with the wrapped values and overflow checked for rows 1-2 (e.g. 150 -> −106, overflow=1).
- Transpose size=5, a(r,c)=r*5+c -> result(r,c)=c*5+r; scalar mul factor=−2 on the same A -> result(1,1)=−12.
- Illegal commands: size=0, size=6, and operation=6 -> done=error=1 one cycle after start; result retains its prior value; busy stays 0.
- Control: start pulsed during busy -> ignored, original result intact. reset_n low in the 4th busy cycle of a multiply -> all outputs 0 immediately, no done pulse. Then a new add completes normally.
